load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns stores onto a 32-bit word memory,
// extracts and extends loads, and faults on misaligned or illegal-size requests.
module load_store_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respRdata,
  output logic        respFault,
  output logic        memValid,
  output logic        memWriteEnable,
  output logic [31:0] memWriteAddr,
  output logic [31:0] memWriteData,
  output logic [3:0]  memWriteMask,
  output logic [31:0] memReadAddr,
  input  logic [31:0] memReadData
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, uns_q, fault_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;

  logic        hs, illegal;
  logic [31:0] rd_shift, ld_ext;
  logic [3:0]  mask_base;

  assign hs = reqValid && reqReady;

  always_comb begin
    illegal = 1'b0;
    case (reqSize)
      2'd1:    illegal = reqAddr[0];
      2'd2:    illegal = (reqAddr[1:0] != 2'b00);
      2'd3:    illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  // Memory returns the whole aligned word; bring the addressed lane down to bit 0.
  assign rd_shift = memReadData >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_ext = rd_shift;
    case (size_q)
      2'd0:    ld_ext = {{24{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    ld_ext = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
      default: ld_ext = rd_shift;
    endcase
  end

  always_comb begin
    mask_base = 4'b0000;
    case (size_q)
      2'd0:    mask_base = 4'b0001;
      2'd1:    mask_base = 4'b0011;
      2'd2:    mask_base = 4'b1111;
      default: mask_base = 4'b0000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hs) begin
        write_q <= reqWrite;
        addr_q  <= reqAddr;
        wdata_q <= reqWdata;
        size_q  <= reqSize;
        uns_q   <= reqUnsigned;
        fault_q <= illegal;
        rdata_q <= '0;
      end
      // The memory is combinational, so the read word is valid by the end of ACCESS.
      if (state_q == ACCESS)
        rdata_q <= write_q ? 32'd0 : ld_ext;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    reqReady       = 1'b0;
    respValid      = 1'b0;
    memValid       = 1'b0;
    memWriteEnable = 1'b0;
    memWriteAddr   = '0;
    memReadAddr    = '0;
    memWriteData   = '0;
    memWriteMask   = '0;
    case (state_q)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) state_d = illegal ? RESP : ACCESS;
      end
      ACCESS: begin
        memValid     = 1'b1;
        memWriteAddr = {addr_q[31:2], 2'b00};
        memReadAddr  = {addr_q[31:2], 2'b00};
        if (write_q) begin
          memWriteEnable = 1'b1;
          memWriteData   = wdata_q << {addr_q[1:0], 3'b000};
          memWriteMask   = mask_base << addr_q[1:0];
        end
        if (MEM_LATENCY <= 1) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_M1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP: begin
        respValid = 1'b1;
        if (respReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign respRdata = (state_q == RESP) ? rdata_q : 32'd0;
  assign respFault = (state_q == RESP) && fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level memory model and reference, directed
// scenarios plus randomized transactions.
module tb_load_store_unit;
  localparam int LAT = 4;

  logic        clock = 1'b0, reset = 1'b1;
  logic        reqValid = 1'b0, reqWrite = 1'b0, reqUnsigned = 1'b0, respReady = 1'b0;
  logic [31:0] reqAddr = '0, reqWdata = '0;
  logic [1:0]  reqSize = '0;
  logic        reqReady, respValid, respFault, memValid, memWriteEnable;
  logic [31:0] respRdata, memWriteAddr, memWriteData, memReadAddr;
  logic [3:0]  memWriteMask;
  logic [31:0] memReadData = '0;

  int n_cmp = 0, n_err = 0;

  always #5 clock = ~clock;

  load_store_unit #(.MEM_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
    .reqWrite(reqWrite), .reqAddr(reqAddr), .reqWdata(reqWdata), .reqSize(reqSize),
    .reqUnsigned(reqUnsigned), .respValid(respValid), .respReady(respReady),
    .respRdata(respRdata), .respFault(respFault), .memValid(memValid),
    .memWriteEnable(memWriteEnable), .memWriteAddr(memWriteAddr),
    .memWriteData(memWriteData), .memWriteMask(memWriteMask),
    .memReadAddr(memReadAddr), .memReadData(memReadData)
  );

  // Memory window of 64 bytes at 0x80000000 (index by addr[5:0]).
  logic [7:0]  mem_b [0:63];
  logic [7:0]  ref_b [0:63];
  int          strobes = 0;
  logic [31:0] last_waddr = '0, last_raddr = '0, last_wdata = '0;
  logic [3:0]  last_mask = '0;
  logic        last_we = 1'b0;

  function automatic logic [7:0] init_byte(input int i);
    logic [7:0] x;
    x = 8'(i);
    return (x * 8'd37) ^ 8'h5C;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_b[i] = init_byte(i);
      ref_b[i] = init_byte(i);
    end
  end

  always @(negedge clock) begin
    logic [31:0] ra;
    ra = memReadAddr;
    memReadData = {mem_b[6'(ra[5:0] + 6'd3)], mem_b[6'(ra[5:0] + 6'd2)],
                   mem_b[6'(ra[5:0] + 6'd1)], mem_b[ra[5:0]]};
  end

  always @(posedge clock) begin
    if (memValid) begin
      strobes    <= strobes + 1;
      last_waddr <= memWriteAddr;
      last_raddr <= memReadAddr;
      last_wdata <= memWriteData;
      last_mask  <= memWriteMask;
      last_we    <= memWriteEnable;
      if (memWriteEnable)
        for (int i = 0; i < 4; i++)
          if (memWriteMask[i]) mem_b[6'(memWriteAddr[5:0] + 6'(i))] <= memWriteData[8*i +: 8];
    end
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic is_illegal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[6'(a[5:0] + 6'(i))]) << (8 * i));
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    for (int i = 0; i < nbytes(sz); i++) ref_b[6'(a[5:0] + 6'(i))] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a, input logic use_mem);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      v[8*i +: 8] = use_mem ? mem_b[{a[5:2], 2'(i)}] : ref_b[{a[5:2], 2'(i)}];
    return v;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Runs one transaction and reports what was observed.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic u, input int stall, input logic hold,
                         output logic [31:0] rd, output logic flt, output int lat, output int nstb,
                         output int stb_cyc, output logic zero_bad, output logic stable_bad,
                         output logic busy_bad, output logic post_ok, output int wait_n);
    int s0, cyc;
    reqValid = 1'b1; reqWrite = w; reqAddr = a; reqWdata = d; reqSize = sz; reqUnsigned = u;
    respReady = 1'b0;
    zero_bad = 0; stable_bad = 0; busy_bad = 0; stb_cyc = -1; wait_n = 0;
    while (!reqReady && wait_n < 20) begin tick(); wait_n++; end
    s0 = strobes;
    tick();
    if (!hold) reqValid = 1'b0;
    cyc = 1;
    while (!respValid && cyc < 40) begin
      if (reqReady) busy_bad = 1;
      if (memValid) begin
        if (stb_cyc < 0) stb_cyc = cyc;
      end else if (memWriteEnable || memWriteMask != 0 || memWriteAddr != 0 ||
                   memReadAddr != 0 || memWriteData != 0) zero_bad = 1;
      tick();
      cyc++;
    end
    lat = cyc;
    rd  = respRdata;
    flt = respFault;
    for (int k = 0; k <= stall; k++) begin
      if (k == stall) respReady = 1'b1;
      if (!respValid || respRdata !== rd || respFault !== flt) stable_bad = 1;
      if (reqReady || memValid) busy_bad = 1;
      tick();
    end
    respReady = 1'b0;
    post_ok = (reqReady === 1'b1) && (respValid === 1'b0) && (respRdata === 32'd0) && (respFault === 1'b0);
    nstb = strobes - s0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int s0;
    reset = 1'b1; reqValid = 1'b1; reqAddr = 32'h8000_0000;
    tick(); tick();
    reset = 1'b0; reqValid = 1'b0;
    n_cmp++;
    if ({reqReady, respValid, respFault} !== 3'b100) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 100", {reqReady, respValid, respFault});
    end
    n_cmp++;
    if (respRdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", respRdata); end
    n_cmp++;
    if ({memValid, memWriteEnable, memWriteMask, memWriteAddr, memReadAddr, memWriteData} !== '0) begin
      n_err++; $display("FAIL reset_mem: got v=%b we=%b m=%b not all zero", memValid, memWriteEnable, memWriteMask);
    end
    s0 = strobes;
    tick();
    n_cmp++;
    if (reqReady !== 1'b1 || strobes != s0) begin
      n_err++; $display("FAIL reset_ignore_req: got ready=%b strobes=%0d want 1/%0d", reqReady, strobes, s0);
    end
  endtask

  task automatic test_store_byte;
    logic [31:0] rd; logic flt, zb, sb, bb, po; int lat, ns, sc, wn;
    run_txn(1'b1, 32'h8000_0003, 32'h0000_00AB, 2'd0, 1'b0, 0, 1'b0,
            rd, flt, lat, ns, sc, zb, sb, bb, po, wn);
    model_store(32'h8000_0003, 32'h0000_00AB, 2'd0);
    n_cmp++; if (ns != 1) begin n_err++; $display("FAIL sb_strobes: got %0d want 1", ns); end
    n_cmp++; if (last_waddr !== 32'h8000_0000) begin n_err++; $display("FAIL sb_waddr: got %h want 80000000", last_waddr); end
    n_cmp++; if (last_wdata !== 32'hAB00_0000) begin n_err++; $display("FAIL sb_wdata: got %h want ab000000", last_wdata); end
    n_cmp++; if (last_mask !== 4'b1000 || last_we !== 1'b1) begin n_err++; $display("FAIL sb_mask: got %b we=%b want 1000 we=1", last_mask, last_we); end
    n_cmp++; if (lat != LAT + 1) begin n_err++; $display("FAIL sb_latency: got %0d want %0d", lat, LAT + 1); end
    n_cmp++; if (rd !== 32'd0 || flt !== 1'b0) begin n_err++; $display("FAIL sb_resp: got %h f=%b want 0 f=0", rd, flt); end
    n_cmp++; if (word_of(32'h8000_0000, 1) !== word_of(32'h8000_0000, 0)) begin
      n_err++; $display("FAIL sb_memword: got %h want %h", word_of(32'h8000_0000, 1), word_of(32'h8000_0000, 0));
    end
    n_cmp++; if (!po || zb || bb) begin n_err++; $display("FAIL sb_protocol: got post=%b zero_bad=%b busy_bad=%b want 1/0/0", po, zb, bb); end
  endtask

  task automatic test_load_half;
    logic [31:0] rd; logic flt, zb, sb, bb, po; int lat, ns, sc, wn;
    for (int i = 0; i < 4; i++) begin
      mem_b[i] = 8'(32'h8765_1234 >> (8 * i));
      ref_b[i] = 8'(32'h8765_1234 >> (8 * i));
    end
    run_txn(1'b0, 32'h8000_0002, 32'hDEAD_BEEF, 2'd1, 1'b0, 1, 1'b0,
            rd, flt, lat, ns, sc, zb, sb, bb, po, wn);
    n_cmp++; if (rd !== 32'hFFFF_8765) begin n_err++; $display("FAIL lh_signed: got %h want ffff8765", rd); end
    n_cmp++; if (last_we !== 1'b0 || last_mask !== 4'b0 || last_raddr !== 32'h8000_0000) begin
      n_err++; $display("FAIL lh_strobe: got we=%b m=%b ra=%h want 0/0000/80000000", last_we, last_mask, last_raddr);
    end
    run_txn(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 0, 1'b0,
            rd, flt, lat, ns, sc, zb, sb, bb, po, wn);
    n_cmp++; if (rd !== 32'h0000_8765) begin n_err++; $display("FAIL lh_unsigned: got %h want 00008765", rd); end
    n_cmp++; if (ns != 1 || sc != 1) begin n_err++; $display("FAIL lh_strobes: got n=%0d at %0d want 1 at 1", ns, sc); end
  endtask

  task automatic test_fault;
    logic [31:0] rd; logic flt, zb, sb, bb, po; int lat, ns, sc, wn;
    run_txn(1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0, 2, 1'b0,
            rd, flt, lat, ns, sc, zb, sb, bb, po, wn);
    n_cmp++; if (ns != 0) begin n_err++; $display("FAIL flt_strobes: got %0d want 0", ns); end
    n_cmp++; if (flt !== 1'b1 || rd !== 32'd0) begin n_err++; $display("FAIL flt_resp: got f=%b %h want f=1 0", flt, rd); end
    n_cmp++; if (lat != 1 || sb || !po) begin n_err++; $display("FAIL flt_timing: got lat=%0d stable_bad=%b post=%b want 1/0/1", lat, sb, po); end
    run_txn(1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0, 0, 1'b0,
            rd, flt, lat, ns, sc, zb, sb, bb, po, wn);
    n_cmp++; if (wn != 0 || rd !== 32'h8765_1234 || flt !== 1'b0) begin
      n_err++; $display("FAIL flt_next: got wait=%0d %h f=%b want 0 87651234 f=0", wn, rd, flt);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd, exp; logic flt, zb, sb, bb, po; int lat, ns, sc, wn;
    exp = model_load(32'h8000_0010, 2'd2, 1'b0);
    run_txn(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0, 5, 1'b0,
            rd, flt, lat, ns, sc, zb, sb, bb, po, wn);
    n_cmp++; if (lat != LAT + 1) begin n_err++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT + 1); end
    n_cmp++; if (sb || bb) begin n_err++; $display("FAIL bp_stable: got stable_bad=%b busy_bad=%b want 0/0", sb, bb); end
    n_cmp++; if (rd !== exp || ns != 1) begin n_err++; $display("FAIL bp_data: got %h n=%0d want %h n=1", rd, ns, exp); end
  endtask

  task automatic test_reset_wait;
    int s0, late;
    s0 = strobes;
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h8000_0020; reqSize = 2'd2; reqUnsigned = 1'b0;
    tick();
    reqValid = 1'b0;
    tick(); tick();
    reset = 1'b1; reqValid = 1'b1;
    tick();
    reset = 1'b0; reqValid = 1'b0;
    n_cmp++;
    if (reqReady !== 1'b1 || respValid !== 1'b0) begin
      n_err++; $display("FAIL rw_idle: got ready=%b valid=%b want 1/0", reqReady, respValid);
    end
    late = 0;
    for (int i = 0; i < 10; i++) begin
      if (respValid) late = 1;
      tick();
    end
    n_cmp++;
    if (late != 0 || strobes - s0 != 1) begin
      n_err++; $display("FAIL rw_no_resp: got late=%0d strobes=%0d want 0/1", late, strobes - s0);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd, e1, e2; logic flt, zb, sb, bb, po; int lat, ns, sc, wn;
    e1 = model_load(32'h8000_0004, 2'd0, 1'b1);
    e2 = model_load(32'h8000_0006, 2'd1, 1'b0);
    run_txn(1'b0, 32'h8000_0004, 32'h0, 2'd0, 1'b1, 1, 1'b1,
            rd, flt, lat, ns, sc, zb, sb, bb, po, wn);
    n_cmp++; if (rd !== e1 || bb || !po || ns != 1) begin
      n_err++; $display("FAIL b2b_first: got %h busy_bad=%b post=%b n=%0d want %h 0/1/1", rd, bb, po, ns, e1);
    end
    run_txn(1'b0, 32'h8000_0006, 32'h0, 2'd1, 1'b0, 0, 1'b0,
            rd, flt, lat, ns, sc, zb, sb, bb, po, wn);
    n_cmp++; if (wn != 0 || rd !== e2 || ns != 1) begin
      n_err++; $display("FAIL b2b_second: got wait=%0d %h n=%0d want 0 %h 1", wn, rd, ns, e2);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, d, exp_rd; logic flt, zb, sb, bb, po, w, u, exp_f; logic [1:0] sz;
    int lat, ns, sc, wn, off;
    for (int t = 0; t < 60; t++) begin
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      off = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) off = off & ~1;
        else if (sz == 2'd2) off = off & ~3;
      end
      a = 32'h8000_0000 | 32'(off);
      d = $urandom;
      exp_f  = is_illegal(sz, a);
      exp_rd = (exp_f || w) ? 32'd0 : model_load(a, sz, u);
      run_txn(w, a, d, sz, u, $urandom_range(0, 3), 1'b0,
              rd, flt, lat, ns, sc, zb, sb, bb, po, wn);
      if (!exp_f && w) model_store(a, d, sz);
      n_cmp++; if (rd !== exp_rd || flt !== exp_f) begin
        n_err++; $display("FAIL rnd_resp[%0d]: got %h f=%b want %h f=%b (a=%h sz=%0d w=%b)", t, rd, flt, exp_rd, exp_f, a, sz, w);
      end
      n_cmp++; if (lat != (exp_f ? 1 : LAT + 1) || ns != (exp_f ? 0 : 1)) begin
        n_err++; $display("FAIL rnd_timing[%0d]: got lat=%0d n=%0d want %0d/%0d", t, lat, ns, exp_f ? 1 : LAT + 1, exp_f ? 0 : 1);
      end
      n_cmp++; if (zb || sb || bb || !po || (!exp_f && sc != 1)) begin
        n_err++; $display("FAIL rnd_protocol[%0d]: got zero=%b stable=%b busy=%b post=%b sc=%0d", t, zb, sb, bb, po, sc);
      end
      n_cmp++; if (word_of(a, 1) !== word_of(a, 0)) begin
        n_err++; $display("FAIL rnd_mem[%0d]: got %h want %h", t, word_of(a, 1), word_of(a, 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_half();
    test_fault();
    test_backpressure();
    test_reset_wait();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
